// File: rtl/viterbi_pkg.sv
// Shared defaults, helpers and FSM encoding for the Viterbi survivor path.
package viterbi_pkg;

    localparam int DEF_NUM_STATES = 64;
    localparam int DEF_TB_LEN     = 32;

    function automatic int state_width(input int num_states);
        return (num_states <= 2) ? 1 : $clog2(num_states);
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        TRAIN,
        DECODE,
        HOLD
    } tb_state_t;

endpackage

// File: rtl/surv_col_ram.sv
// Column store for survivor decisions: one synchronous write port, one asynchronous read port.
module surv_col_ram
    import viterbi_pkg::*;
#(
    parameter int DEPTH = 3 * DEF_TB_LEN,
    parameter int WIDTH = DEF_NUM_STATES,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/surv_tb_mem.sv
// Survivor memory with sliding-block traceback for the pipelined Viterbi decoder.
// Optional SURV_TB_BEST_STATE_EN adds a best_state input used as the traceback start state.
module surv_tb_mem
    import viterbi_pkg::*;
#(
    parameter int NUM_STATES = DEF_NUM_STATES,
    parameter int TB_LEN     = DEF_TB_LEN,
    parameter int SW         = state_width(NUM_STATES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STATES-1:0] dec_vec,
    input  logic                  dec_valid,
    output logic                  dec_ready,
`ifdef SURV_TB_BEST_STATE_EN
    input  logic [SW-1:0]         best_state,
`endif
    output logic [TB_LEN-1:0]     data_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  tb_busy
);

    localparam int DEPTH = 3 * TB_LEN;
    localparam int PW    = $clog2(DEPTH);
    localparam int CW    = $clog2(2 * TB_LEN + 1);
    localparam int KW    = (TB_LEN > 2) ? $clog2(TB_LEN) : 1;

    localparam logic [PW-1:0] PTR_LAST   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] THR_FIRST  = CW'(2 * TB_LEN);
    localparam logic [CW-1:0] THR_STEADY = CW'(TB_LEN);
    localparam logic [KW-1:0] STEP_LAST  = KW'(TB_LEN - 1);

    tb_state_t fsm, fsm_nxt;

    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         pend_cnt;
    logic                  first;
    logic [SW-1:0]         cur_state;
    logic [KW-1:0]         step_cnt;
    logic [TB_LEN-1:0]     shift_reg;
    logic [NUM_STATES-1:0] rd_col;
    logic [CW-1:0]         thr;
    logic                  accept;
    logic                  start_tb;
    logic                  walking;
    logic                  last_step;
    logic                  tb_bit;
    logic [SW-1:0]         trace_nxt;
    logic [TB_LEN-1:0]     word_full;
    logic [TB_LEN-1:0]     out_word;
    logic                  load_out;
    logic [SW-1:0]         start_state;

`ifdef SURV_TB_BEST_STATE_EN
    assign start_state = best_state;
`else
    assign start_state = '0;
`endif

    // The first block needs a full training plus decode window; later blocks reuse the previous training columns.
    assign thr       = first ? THR_FIRST : THR_STEADY;
    assign dec_ready = (pend_cnt < thr);
    assign accept    = dec_valid && dec_ready;
    assign start_tb  = (fsm == IDLE) && (pend_cnt == thr);
    assign walking   = (fsm == TRAIN) || (fsm == DECODE);
    assign last_step = (step_cnt == STEP_LAST);
    assign tb_busy   = (fsm != IDLE);

    assign tb_bit    = cur_state[SW-1];
    assign trace_nxt = {cur_state[SW-2:0], rd_col[cur_state]};
    assign word_full = {shift_reg[TB_LEN-2:0], tb_bit};

    surv_col_ram #(
        .DEPTH (DEPTH),
        .WIDTH (NUM_STATES),
        .AW    (PW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (dec_vec),
        .rd_addr (rd_ptr),
        .rd_data (rd_col)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt  = fsm;
        load_out = 1'b0;
        out_word = shift_reg;
        case (fsm)
            IDLE: begin
                if (pend_cnt == thr) begin
                    fsm_nxt = TRAIN;
                end
            end
            TRAIN: begin
                if (last_step) begin
                    fsm_nxt = DECODE;
                end
            end
            DECODE: begin
                if (last_step) begin
                    if (!out_valid || out_ready) begin
                        load_out = 1'b1;
                        out_word = word_full;
                        fsm_nxt  = IDLE;
                    end else begin
                        fsm_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    load_out = 1'b1;
                    fsm_nxt  = IDLE;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            pend_cnt <= '0;
            first    <= 1'b1;
        end else begin
            if (accept) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (start_tb) begin
                pend_cnt <= '0;
                first    <= 1'b0;
            end else if (accept) begin
                pend_cnt <= pend_cnt + CW'(1);
            end
        end
    end

    // Traceback walks backwards from the newest column; decoded bits enter at the LSB so the oldest step ends up in bit 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr    <= '0;
            cur_state <= '0;
            step_cnt  <= '0;
            shift_reg <= '0;
        end else if (start_tb) begin
            rd_ptr    <= (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);
            cur_state <= start_state;
            step_cnt  <= '0;
        end else if (walking) begin
            rd_ptr    <= (rd_ptr == '0) ? PTR_LAST : rd_ptr - PW'(1);
            cur_state <= trace_nxt;
            step_cnt  <= last_step ? '0 : step_cnt + KW'(1);
            if (fsm == DECODE) begin
                shift_reg <= word_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out  <= '0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            data_out  <= out_word;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_surv_tb_mem.sv
// Randomized self-checking bench for surv_tb_mem against a history-based traceback model.
module tb_surv_tb_mem;

    localparam int NS = 4;
    localparam int TB = 8;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] dec_vec = '0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [TB-1:0] data_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          tb_busy;
`ifdef SURV_TB_BEST_STATE_EN
    logic [SW-1:0] best_state = '0;
`endif

    int total_cnt = 0;
    int bad_cnt = 0;
    logic [NS-1:0] hist[$];
    logic [TB-1:0] exp_q[$];
    int  n_acc = 0;
    int  words_seen = 0;
    int  start_state = 0;
    bit  rand_ready = 0;

    always #5 clk = ~clk;

    surv_tb_mem #(
        .NUM_STATES (NS),
        .TB_LEN     (TB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_vec    (dec_vec),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
`ifdef SURV_TB_BEST_STATE_EN
        .best_state (best_state),
`endif
        .data_out   (data_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .tb_busy    (tb_busy)
    );

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            bad_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
        end
    endtask

    // Word ending at accepted column n: walk 2*TB columns back from the newest, keep the MSB of the older half.
    function automatic logic [TB-1:0] model_word(input int n);
        int            st;
        logic [NS-1:0] c;
        logic [TB-1:0] w;
        st = start_state;
        w  = '0;
        for (int j = 0; j < 2 * TB; j++) begin
            c = hist[n - 1 - j];
            if (j >= TB) begin
                w[2 * TB - 1 - j] = ((st >> (SW - 1)) & 1) != 0;
            end
            st = (2 * st + int'(c[st])) % NS;
        end
        return w;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (dec_valid && dec_ready) begin
                hist.push_back(dec_vec);
                n_acc++;
                if (n_acc >= 2 * TB && (n_acc % TB) == 0) begin
                    exp_q.push_back(model_word(n_acc));
                end
            end
            if (out_valid && out_ready) begin
                words_seen++;
                if (exp_q.size() == 0) begin
                    check_output("spurious_word", 32'(out_valid), 32'(0));
                end else begin
                    check_output("word", 32'(data_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic clear_model();
        hist.delete();
        exp_q.delete();
        n_acc = 0;
        words_seen = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        dec_valid = 1'b0;
        dec_vec = '0;
        clear_model();
`ifdef SURV_TB_BEST_STATE_EN
        start_state = int'($urandom_range(0, NS - 1));
        best_state = SW'(start_state);
`endif
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic apply_stimulus(input logic [NS-1:0] v);
        bit ok;
        ok = 0;
        dec_vec = v;
        dec_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = dec_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        dec_valid = 1'b0;
        check_output("accept", 32'(ok), 32'(1));
    endtask

    task automatic wait_word(input int limit, output int edges);
        edges = 0;
        while (!out_valid && edges < limit) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    initial begin
        int edges;
        int seen;

        #2 rst = 1'b0;
        #10;
        check_output("rst_out_valid", 32'(out_valid), 32'(0));
        check_output("rst_dec_ready", 32'(dec_ready), 32'(1));
        check_output("rst_tb_busy", 32'(tb_busy), 32'(0));
        check_output("rst_data_out", 32'(data_out), 32'(0));

        // All-zero decisions: exact latency and threshold stall.
        do_reset();
        for (int i = 0; i < 2 * TB; i++) apply_stimulus('0);
        check_output("ready_low_at_thr", 32'(dec_ready), 32'(0));
        wait_word(60, edges);
        check_output("first_latency", 32'(edges), 32'(2 * TB + 1));
        check_output("zero_word", 32'(data_out), 32'(0));
        @(posedge clk);
        #1;
        check_output("valid_clears", 32'(out_valid), 32'(0));

        // All-one decisions converge to the top state.
        do_reset();
        for (int i = 0; i < 2 * TB; i++) apply_stimulus('1);
        wait_word(60, edges);
        check_output("ones_word", 32'(data_out), 32'hFF);
        idle_cycles(2);

        // Reset while decoding aborts everything immediately.
        do_reset();
        for (int i = 0; i < 2 * TB; i++) apply_stimulus(NS'($urandom));
        idle_cycles(TB + 3);
        check_output("busy_in_decode", 32'(tb_busy), 32'(1));
        rst = 1'b0;
        #1;
        check_output("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check_output("mid_rst_dec_ready", 32'(dec_ready), 32'(1));
        check_output("mid_rst_tb_busy", 32'(tb_busy), 32'(0));
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2 * TB - 1; i++) apply_stimulus(NS'($urandom));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_output("no_early_word", 32'(seen), 32'(0));
        apply_stimulus(NS'($urandom));
        wait_word(60, edges);
        check_output("restart_latency", 32'(edges), 32'(2 * TB + 1));
        idle_cycles(3);

        // Output backpressure: one word held, the next parked, writer stalled.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 4 * TB; i++) apply_stimulus(NS'($urandom));
        idle_cycles(2 * TB + 5);
        check_output("hold_busy", 32'(tb_busy), 32'(1));
        check_output("hold_dec_ready", 32'(dec_ready), 32'(0));
        check_output("hold_out_valid", 32'(out_valid), 32'(1));
        check_output("held_word", 32'(data_out), 32'(exp_q[0]));
        out_ready = 1'b1;
        for (int i = 0; i < TB; i++) apply_stimulus(NS'($urandom));
        idle_cycles(6 * TB);
        check_output("bp_words", 32'(words_seen), 32'(4));
        check_output("bp_drained", 32'(exp_q.size()), 32'(0));

        // Long random run across many buffer wraps with random gaps and stalls.
        do_reset();
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            apply_stimulus(NS'($urandom));
        end
        rand_ready = 0;
        out_ready = 1'b1;
        idle_cycles(6 * TB);
        check_output("rand_words", 32'(words_seen), 32'((200 - 2 * TB) / TB + 1));
        check_output("rand_drained", 32'(exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
